// File: rtl/sm_mcu_cpu_oci_dct_packer.sv
// Packs 3-bit trace fragments into 30-bit frames with a one-deep output slot.
// Partial buffers flush on an idle timeout or on test_ending, which then ends capture.
module sm_mcu_cpu_oci_dct_packer #(
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        frag_valid,
    input  logic [2:0]  frag_data,
    output logic        frag_ready,
    input  logic        test_ending,
    output logic [29:0] dct_buffer,
    output logic [3:0]  dct_count,
    output logic        out_valid,
    output logic [35:0] out_data,
    input  logic        out_ready,
    output logic        test_has_ended
);
    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never depends on ready, and out_data holds while out_valid && !out_ready.
    typedef enum logic [1:0] {ST_FILL, ST_FLUSH, ST_DRAIN, ST_ENDED} state_t;

    localparam logic [7:0] TIMEOUT = 8'(FLUSH_TIMEOUT);

    state_t      state_q, state_d;
    logic [29:0] buf_q, buf_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [7:0]  idle_q, idle_d;
    logic        end_pend_q, end_pend_d;
    logic        out_valid_q, out_valid_d;
    logic [35:0] out_data_q, out_data_d;

    logic        slot_free;
    logic        accept;
    logic        full;
    logic        load;
    state_t      exit_state;

    assign slot_free  = !out_valid_q || out_ready;
    assign full       = (cnt_q == 4'd10);
    assign accept     = frag_valid && frag_ready;
    assign exit_state = (end_pend_q || test_ending) ? ST_DRAIN : ST_FILL;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_FILL;
            buf_q       <= '0;
            cnt_q       <= '0;
            idle_q      <= '0;
            end_pend_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
            idle_q      <= idle_d;
            end_pend_q  <= end_pend_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        end_pend_d = end_pend_q;
        case (state_q)
            ST_FILL: begin
                if (test_ending) begin
                    end_pend_d = 1'b1;
                    state_d    = ST_FLUSH;
                end else if (idle_q == TIMEOUT) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                // A test_ending during a timeout flush redirects the exit to DRAIN.
                if (test_ending) end_pend_d = 1'b1;
                if (cnt_q == 4'd0 || slot_free) state_d = exit_state;
            end
            ST_DRAIN: begin
                if (slot_free) state_d = ST_ENDED;
            end
            default: state_d = ST_ENDED;
        endcase
    end

    always_comb begin
        buf_d       = buf_q;
        cnt_d       = cnt_q;
        idle_d      = idle_q;
        out_valid_d = out_valid_q && !out_ready;
        out_data_d  = out_data_q;
        load        = slot_free && (((state_q == ST_FILL) && full) ||
                                    ((state_q == ST_FLUSH) && (cnt_q != 4'd0)));
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = {(full ? 2'b01 : 2'b10), cnt_q, buf_q};
            buf_d       = '0;
            cnt_d       = '0;
        end else if (accept) begin
            buf_d = {buf_q[26:0], frag_data};
            cnt_d = cnt_q + 4'd1;
        end
        // A full buffer waiting on the slot neither counts nor clears idle time.
        if (state_q != ST_FILL || accept || load || cnt_q == 4'd0) begin
            idle_d = '0;
        end else if (!full && idle_q != TIMEOUT) begin
            idle_d = idle_q + 8'd1;
        end
    end

    always_comb begin
        frag_ready     = (state_q == ST_FILL) && (cnt_q < 4'd10);
        test_has_ended = (state_q == ST_ENDED);
        dct_buffer     = buf_q;
        dct_count      = cnt_q;
        out_valid      = out_valid_q;
        out_data       = out_data_q;
    end
endmodule

// File: tb/tb_sm_mcu_cpu_oci_dct_packer.sv
// Directed bench for the trace fragment packer, built with a short flush timeout.
module tb_sm_mcu_cpu_oci_dct_packer;
    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frag_valid = 1'b0;
    logic [2:0]  frag_data = 3'd0;
    logic        frag_ready;
    logic        test_ending = 1'b0;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        out_valid;
    logic [35:0] out_data;
    logic        out_ready = 1'b1;
    logic        test_has_ended;

    int checks = 0;
    int failures = 0;
    logic [35:0] exp_q[$];

    sm_mcu_cpu_oci_dct_packer #(.FLUSH_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .frag_valid(frag_valid), .frag_data(frag_data),
        .frag_ready(frag_ready), .test_ending(test_ending), .dct_buffer(dct_buffer),
        .dct_count(dct_count), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .test_has_ended(test_has_ended)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the fragment is accepted.
    task automatic send(input logic [2:0] d);
        int guard;
        guard = 0;
        frag_valid = 1'b1;
        frag_data  = d;
        while (!frag_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 50) chk("send_ready_timeout", {35'd0, frag_ready}, 36'd1);
        @(negedge clk);
        frag_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, output int cyc);
        logic [35:0] e;
        e = exp_q.pop_front();
        cyc = 0;
        while (!out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_valid"}, {35'd0, out_valid}, 36'd1);
        chk({tag, "_data"}, out_data, e);
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        int cyc;
        logic seen;

        // Reset
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_ready", {35'd0, frag_ready}, 36'd1);
        chk("rst_count", {32'd0, dct_count}, 36'd0);
        chk("rst_buffer", {6'd0, dct_buffer}, 36'd0);
        chk("rst_valid", {35'd0, out_valid}, 36'd0);
        chk("rst_data", out_data, 36'd0);
        chk("rst_ended", {35'd0, test_has_ended}, 36'd0);

        // Ten fragments 1..10 mod 8 make one full frame
        out_ready = 1'b1;
        for (int i = 1; i <= 10; i++) send(3'(i));
        chk("full_count", {32'd0, dct_count}, 36'd10);
        chk("full_buffer", {6'd0, dct_buffer}, {6'd0, 30'b001_010_011_100_101_110_111_000_001_010});
        chk("full_ready", {35'd0, frag_ready}, 36'd0);
        exp_q.push_back({2'b01, 4'd10, 30'b001_010_011_100_101_110_111_000_001_010});
        wait_frame("full", cyc);
        chk("full_count_after", {32'd0, dct_count}, 36'd0);

        // Three fragments then idle: timeout flush
        for (int i = 0; i < 3; i++) send(3'b101);
        chk("to_count", {32'd0, dct_count}, 36'd3);
        exp_q.push_back({2'b10, 4'd3, 21'd0, 9'b101101101});
        wait_frame("timeout", cyc);
        chk("timeout_latency", 36'(cyc), 36'd6);
        chk("timeout_count_after", {32'd0, dct_count}, 36'd0);

        // Backpressure: 20 fragments with the slot blocked
        out_ready = 1'b0;
        for (int i = 0; i < 20; i++) send(3'(i));
        chk("bp_count", {32'd0, dct_count}, 36'd10);
        chk("bp_ready", {35'd0, frag_ready}, 36'd0);
        chk("bp_buffer", {6'd0, dct_buffer}, {6'd0, 30'b010_011_100_101_110_111_000_001_010_011});
        repeat (3) @(negedge clk);
        chk("bp_hold_valid", {35'd0, out_valid}, 36'd1);
        chk("bp_hold_data", out_data, {2'b01, 4'd10, 30'b000_001_010_011_100_101_110_111_000_001});
        exp_q.push_back({2'b01, 4'd10, 30'b000_001_010_011_100_101_110_111_000_001});
        exp_q.push_back({2'b01, 4'd10, 30'b010_011_100_101_110_111_000_001_010_011});
        wait_frame("bp_first", cyc);
        chk("bp_second_immediate", 36'(cyc), 36'd0);
        wait_frame("bp_second", cyc);
        chk("bp_count_after", {32'd0, dct_count}, 36'd0);
        chk("bp_valid_after", {35'd0, out_valid}, 36'd0);

        // test_ending together with the sixth accept
        for (int i = 1; i <= 5; i++) send(3'(i));
        test_ending = 1'b1;
        send(3'd6);
        test_ending = 1'b0;
        chk("end_not_yet", {35'd0, test_has_ended}, 36'd0);
        exp_q.push_back({2'b10, 4'd6, 12'd0, 18'b001_010_011_100_101_110});
        wait_frame("end_frame", cyc);
        chk("end_ended", {35'd0, test_has_ended}, 36'd1);
        frag_valid = 1'b1;
        frag_data  = 3'd5;
        test_ending = 1'b1;
        repeat (5) @(negedge clk);
        frag_valid = 1'b0;
        test_ending = 1'b0;
        chk("end_ignore_count", {32'd0, dct_count}, 36'd0);
        chk("end_ignore_valid", {35'd0, out_valid}, 36'd0);
        chk("end_ignore_ready", {35'd0, frag_ready}, 36'd0);
        chk("end_hold", {35'd0, test_has_ended}, 36'd1);

        // Reset mid-operation: count 7 with a frame pending
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst2_ended", {35'd0, test_has_ended}, 36'd0);
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) send(3'd7);
        chk("mid_count", {32'd0, dct_count}, 36'd7);
        chk("mid_valid", {35'd0, out_valid}, 36'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("mid_rst_count", {32'd0, dct_count}, 36'd0);
        chk("mid_rst_buffer", {6'd0, dct_buffer}, 36'd0);
        chk("mid_rst_valid", {35'd0, out_valid}, 36'd0);
        chk("mid_rst_data", out_data, 36'd0);
        chk("mid_rst_ready", {35'd0, frag_ready}, 36'd1);
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        chk("mid_rst_no_frame", {35'd0, seen}, 36'd0);

        // test_ending with nothing buffered
        test_ending = 1'b1;
        @(negedge clk);
        test_ending = 1'b0;
        cyc = 1;
        seen = out_valid;
        while (!test_has_ended && cyc < 10) begin
            @(negedge clk);
            cyc++;
            seen = seen | out_valid;
        end
        chk("empty_end_cycles", 36'(cyc), 36'd3);
        chk("empty_end_ended", {35'd0, test_has_ended}, 36'd1);
        chk("empty_end_no_frame", {35'd0, seen}, 36'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
